// File: rtl/axi_rd_burst_master_if.sv
// axi_rd_burst_master_if: user command/data stream and AXI4 AR/R channels of the burst read master.
interface axi_rd_burst_master_if #(
  parameter int DW = 128,
  parameter int UW = 16,
  parameter int AW = 32
);
  logic          u2a_valid, u2a_ready;
  logic [AW-1:0] u2a_addr;
  logic [15:0]   u2a_len;
  logic [UW-1:0] user_data;
  logic          user_valid, user_ready, user_last, user_err, err_sticky, busy;
  logic          arvalid, arready, arlock;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, rresp;
  logic [3:0]    arid, arcache, arqos, rid;
  logic [DW-1:0] rdata;
  logic          rvalid, rlast, rready;
  modport master (
    input  u2a_valid, u2a_addr, u2a_len, user_ready, arready, rid, rdata, rresp, rvalid, rlast,
    output u2a_ready, user_data, user_valid, user_last, user_err, err_sticky, busy,
           arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready
  );
  modport slave (
    output u2a_valid, u2a_addr, u2a_len, user_ready, arready, rid, rdata, rresp, rvalid, rlast,
    input  u2a_ready, user_data, user_valid, user_last, user_err, err_sticky, busy,
           arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready
  );
endinterface

// File: rtl/axi_rd_burst_master.sv
// axi_rd_burst_master: splits one user read into 4 KB-safe AXI4 INCR bursts and narrows returned beats to user words.
module axi_rd_burst_master #(
  parameter int         P_AXI_DATA_WIDTH  = 128,
  parameter int         P_USER_DATA_WIDTH = 16,
  parameter int         P_AXI_ADDR_WIDTH  = 32,
  parameter int         P_MAX_BURST       = 16,
  parameter int         P_MAX_OUTSTANDING = 4,
  parameter logic [3:0] P_AXI_ID          = 4'd0
) (
  input logic i_clk,
  input logic i_rst_n,
  axi_rd_burst_master_if.master bus
);
  localparam int R  = P_AXI_DATA_WIDTH / P_USER_DATA_WIDTH;
  localparam int SZ = $clog2(P_AXI_DATA_WIDTH / 8);
  localparam int SW = R > 1 ? $clog2(R) : 1;
  localparam int OW = $clog2(P_MAX_OUTSTANDING + 1);
  localparam int AW = P_AXI_ADDR_WIDTH;
  localparam logic [SW-1:0] LAST = SW'(R - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, next;
  logic                        ready_q, hold_v, hold_e;
  logic [AW-1:0]               cur;
  logic [16:0]                 rem, cap, beats, rcv;
  logic [15:0]                 len_q;
  logic [12:0]                 to4k;
  logic [OW-1:0]               outs;
  logic [P_AXI_DATA_WIDTH-1:0] hold;
  logic [SW-1:0]               slice;
  logic                        accept, ar_hs, r_hs, pop, last_slice, unused_ok;
  assign bus.arsize  = 3'(SZ);
  assign bus.arburst = 2'b01;
  assign bus.arid    = P_AXI_ID;
  assign bus.arlock  = 1'b0;
  assign bus.arcache = 4'h3;
  assign bus.arprot  = 3'd0;
  assign bus.arqos   = 4'd0;
  assign unused_ok   = ^{bus.rid, bus.rresp[0], bus.u2a_addr[SZ-1:0]};
  // Beats left before the next 4 KB page, then clipped by the remaining count and max burst.
  assign to4k  = (13'd4096 - {1'b0, cur[11:0]}) >> SZ;
  assign cap   = rem > 17'(P_MAX_BURST) ? 17'(P_MAX_BURST) : rem;
  assign beats = cap > 17'(to4k) ? 17'(to4k) : cap;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= next;
      ready_q <= next == IDLE;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = ISSUE;
      ISSUE:   if (ar_hs && rem == 17'(bus.arlen) + 17'd1) next = DRAIN;
      DRAIN:   if (pop && bus.user_last) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    last_slice     = slice == LAST;
    accept         = bus.u2a_valid & ready_q;
    ar_hs          = bus.arvalid & bus.arready;
    pop            = hold_v & bus.user_ready;
    bus.rready     = !hold_v | (last_slice & bus.user_ready);
    r_hs           = bus.rvalid & bus.rready;
    bus.u2a_ready  = ready_q;
    bus.busy       = state != IDLE;
    bus.user_valid = hold_v;
    bus.user_data  = hold[slice*P_USER_DATA_WIDTH +: P_USER_DATA_WIDTH];
    bus.user_err   = hold_e;
    bus.user_last  = hold_v & last_slice & (rcv == {1'b0, len_q} + 17'd1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cur            <= '0;
      rem            <= '0;
      len_q          <= '0;
      rcv            <= '0;
      outs           <= '0;
      bus.arvalid    <= 1'b0;
      bus.araddr     <= '0;
      bus.arlen      <= '0;
      hold           <= '0;
      hold_v         <= 1'b0;
      hold_e         <= 1'b0;
      slice          <= '0;
      bus.err_sticky <= 1'b0;
    end else begin
      if (accept) begin
        cur   <= {bus.u2a_addr[AW-1:SZ], SZ'(0)};
        rem   <= 17'(bus.u2a_len) + 17'd1;
        len_q <= bus.u2a_len;
      end else if (ar_hs) begin
        cur <= cur + ((AW'(bus.arlen) + AW'(1)) << SZ);
        rem <= rem - 17'(bus.arlen) - 17'd1;
      end
      if (ar_hs) bus.arvalid <= 1'b0;
      else if (state == ISSUE && !bus.arvalid && outs < OW'(P_MAX_OUTSTANDING)) begin
        bus.arvalid <= 1'b1;
        bus.araddr  <= cur;
        bus.arlen   <= 8'(beats - 17'd1);
      end
      outs <= outs + OW'(ar_hs) - OW'(r_hs & bus.rlast);
      if (r_hs) begin
        hold   <= bus.rdata;
        hold_e <= bus.rresp[1];
      end
      rcv            <= accept ? '0 : rcv + 17'(r_hs);
      hold_v         <= r_hs | (hold_v & !(pop & last_slice));
      slice          <= pop ? (last_slice ? '0 : slice + SW'(1)) : slice;
      bus.err_sticky <= accept ? 1'b0 : bus.err_sticky | (r_hs & bus.rresp[1]);
    end
endmodule

// File: tb/tb_axi_rd_burst_master.sv
// tb_axi_rd_burst_master: directed bench with an in-order AXI read slave and a user-side sink.
module tb_axi_rd_burst_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_rd_burst_master_if #(.DW(128), .UW(16), .AW(32)) bus ();
  axi_rd_burst_master #(
    .P_AXI_DATA_WIDTH(128), .P_USER_DATA_WIDTH(16), .P_AXI_ADDR_WIDTH(32),
    .P_MAX_BURST(16), .P_MAX_OUTSTANDING(4), .P_AXI_ID(4'd0)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int checks = 0, passed = 0, fails = 0;
  int words, bad_data, bad_err, bad_rr, last_cnt, last_idx, err_words, gbeat, beat;
  int r_budget = -1, err_beat = -1, ur_mode = 0;
  bit r_en = 1'b1, arready_v = 1'b1, ur_tog = 1'b0, last_acc, ok;
  logic [31:0] ar_addr[$];
  logic [7:0]  ar_len[$], sq_len[$];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock of slave/sink activity; handshakes are judged at the negedge before the edge that takes them.
  task automatic cycle();
    ur_tog = ~ur_tog;
    bus.arready    = arready_v;
    bus.user_ready = ur_mode == 0 ? 1'b1 : ur_mode == 1 ? ur_tog : 1'b0;
    bus.rvalid     = r_en && sq_len.size() > 0 && r_budget != 0;
    for (int k = 0; k < 8; k++) bus.rdata[16*k +: 16] = 16'(gbeat * 8 + k);
    bus.rresp = gbeat == err_beat ? 2'b10 : 2'b00;
    bus.rlast = sq_len.size() > 0 && beat == int'(sq_len[0]);
    @(negedge clk);
    if (bus.rready !== (!bus.user_valid || (words % 8 == 7 && bus.user_ready))) bad_rr++;
    last_acc = bus.user_valid && bus.user_ready && bus.user_last;
    if (bus.user_valid && bus.user_ready) begin
      if (bus.user_data !== 16'(words)) bad_data++;
      if (bus.user_err !== (words / 8 == err_beat)) bad_err++;
      if (bus.user_err) err_words++;
      if (bus.user_last) begin
        last_cnt++;
        last_idx = words;
      end
      words++;
    end
    if (bus.arvalid && bus.arready) begin
      ar_addr.push_back(bus.araddr);
      ar_len.push_back(bus.arlen);
      sq_len.push_back(bus.arlen);
    end
    if (bus.rvalid && bus.rready) begin
      gbeat++;
      if (r_budget > 0) r_budget--;
      if (bus.rlast) begin
        void'(sq_len.pop_front());
        beat = 0;
      end else beat++;
    end
    @(posedge clk); #1;
  endtask
  task automatic run(int n, bit until_last, output bit done);
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      cycle();
      done = until_last && last_acc;
    end
  endtask
  task automatic cmd(logic [31:0] a, logic [15:0] l, output bit acc);
    {words, bad_data, bad_err, bad_rr, last_cnt, err_words, gbeat, beat} = '0;
    last_idx = -1;
    ar_addr.delete();
    ar_len.delete();
    bus.rvalid    = 1'b0;
    bus.u2a_addr  = a;
    bus.u2a_len   = l;
    bus.u2a_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = bus.u2a_ready;
      @(posedge clk); #1;
    end
    bus.u2a_valid = 1'b0;
  endtask
  initial begin
    {bus.u2a_valid, bus.u2a_addr, bus.u2a_len, bus.user_ready, bus.arready} = '0;
    {bus.rid, bus.rdata, bus.rresp, bus.rvalid, bus.rlast} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_user_valid", bus.user_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_u2a_ready", bus.u2a_ready, 0);
    chk("rst_rready", bus.rready, 1);
    chk("rst_err_sticky", bus.err_sticky, 0);
    chk("arsize", bus.arsize, 4);
    chk("arburst_arcache", {bus.arburst, bus.arcache}, 6'h13);
    chk("arid_lock_prot_qos", {bus.arid, bus.arlock, bus.arprot, bus.arqos}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_u2a_ready", bus.u2a_ready, 1);
    // Single beat; low address bits must be dropped.
    cmd(32'h10F, 16'd0, ok);
    chk("sb_accept", ok, 1);
    chk("sb_busy", bus.busy, 1);
    run(200, 1'b1, ok);
    chk("sb_done", ok, 1);
    chk("sb_ar_cnt", ar_addr.size(), 1);
    chk("sb_araddr", ar_addr[0], 32'h100);
    chk("sb_arlen", ar_len[0], 0);
    chk("sb_words", words, 8);
    chk("sb_data", bad_data, 0);
    chk("sb_last", {last_cnt[7:0], last_idx[15:0]}, {8'd1, 16'd7});
    chk("sb_idle_ready", bus.u2a_ready, 1);
    chk("sb_idle_busy", bus.busy, 0);
    // Max-burst split.
    cmd(32'h0, 16'd39, ok);
    run(1000, 1'b1, ok);
    chk("split_done", ok, 1);
    chk("split_ar_cnt", ar_addr.size(), 3);
    chk("split_ar0", {ar_addr[0], ar_len[0]}, {32'h000, 8'd15});
    chk("split_ar1", {ar_addr[1], ar_len[1]}, {32'h100, 8'd15});
    chk("split_ar2", {ar_addr[2], ar_len[2]}, {32'h200, 8'd7});
    chk("split_words", words, 320);
    chk("split_data", bad_data, 0);
    chk("split_last", {last_cnt[7:0], last_idx[15:0]}, {8'd1, 16'd319});
    // 4 KB crossing.
    cmd(32'hF80, 16'd15, ok);
    run(500, 1'b1, ok);
    chk("4k_done", ok, 1);
    chk("4k_ar_cnt", ar_addr.size(), 2);
    chk("4k_ar0", {ar_addr[0], ar_len[0]}, {32'hF80, 8'd7});
    chk("4k_ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 8'd7});
    chk("4k_words", words, 128);
    chk("4k_data", bad_data, 0);
    // Backpressure: user ready toggles every cycle.
    ur_mode = 1;
    cmd(32'h40, 16'd3, ok);
    run(500, 1'b1, ok);
    chk("bp_done", ok, 1);
    chk("bp_ar", {ar_addr[0], ar_len[0]}, {32'h40, 8'd3});
    chk("bp_words", words, 32);
    chk("bp_data", bad_data, 0);
    chk("bp_rready", bad_rr, 0);
    chk("bp_last", {last_cnt[7:0], last_idx[15:0]}, {8'd1, 16'd31});
    // Error on beat 2 of 4.
    ur_mode  = 0;
    err_beat = 2;
    cmd(32'h0, 16'd3, ok);
    run(500, 1'b1, ok);
    chk("err_done", ok, 1);
    chk("err_words", err_words, 8);
    chk("err_flags", bad_err, 0);
    chk("err_data", bad_data, 0);
    run(3, 1'b0, ok);
    chk("err_sticky_held", bus.err_sticky, 1);
    err_beat = -1;
    // Outstanding limit.
    r_en = 1'b0;
    cmd(32'h0, 16'd127, ok);
    chk("os_sticky_clr", bus.err_sticky, 0);
    run(30, 1'b0, ok);
    chk("os_ar_cnt", ar_addr.size(), 4);
    chk("os_arvalid_blk", bus.arvalid, 0);
    r_en     = 1'b1;
    r_budget = 16;
    run(200, 1'b0, ok);
    chk("os_ar_cnt2", ar_addr.size(), 5);
    chk("os_ar4", {ar_addr[4], ar_len[4]}, {32'h400, 8'd15});
    chk("os_arvalid_blk2", bus.arvalid, 0);
    chk("os_words", words, 128);
    chk("os_rready", bad_rr, 0);
    // Park a stuck AR and a held beat, then reset asynchronously.
    arready_v = 1'b0;
    r_budget  = 17;
    run(200, 1'b0, ok);
    chk("pre_words", words, 264);
    chk("pre_data", bad_data, 0);
    ur_mode  = 2;
    r_budget = 1;
    run(5, 1'b0, ok);
    chk("pre_arvalid", bus.arvalid, 1);
    chk("pre_user_valid", bus.user_valid, 1);
    chk("pre_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", bus.arvalid, 0);
    chk("mid_rst_user_valid", bus.user_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_u2a_ready", bus.u2a_ready, 0);
    chk("mid_rst_rready", bus.rready, 1);
    sq_len.delete();
    {arready_v, r_budget, ur_mode} = {1'b1, -1, 0};
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(32'h200, 16'd0, ok);
    chk("rec_accept", ok, 1);
    run(200, 1'b1, ok);
    chk("rec_done", ok, 1);
    chk("rec_ar", {ar_addr[0], ar_len[0]}, {32'h200, 8'd0});
    chk("rec_words", words, 8);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
- Single-clock, parametrised AXI4 read master. Takes one user read command of up to 65536 AXI beats and splits it into legal INCR bursts, bounded by P_MAX_BURST and the 4 KB boundary.
- Keeps up to P_MAX_OUTSTANDING bursts in flight.
- Down-converts each returned AXI beat into P_AXI_DATA_WIDTH/P_USER_DATA_WIDTH user words, with full user-side backpressure.
- Sits between user logic and the AXI interconnect / memory controller on the same clock domain. No CDC FIFOs.

Parameters:
- P_AXI_DATA_WIDTH, 128, AXI data width in bits (64/128/256/512).
- P_USER_DATA_WIDTH, 16, user data width in bits. It must divide P_AXI_DATA_WIDTH, and the ratio R = AXI/USER must be a power of two (R = 1 allowed).
- P_AXI_ADDR_WIDTH, 32, AXI address width.
- P_MAX_BURST, 16, maximum beats per burst (1..256).
- P_MAX_OUTSTANDING, 4, maximum issued-but-incomplete bursts (1..16).
- P_AXI_ID, 0, constant ARID value (4 bits).

Ports:
- i_clk in 1: single clock.
- i_rst_n in 1: asynchronous active-low reset.
- i_u2a_valid in 1: command valid.
- o_u2a_ready out 1: command ready.
- i_u2a_addr in P_AXI_ADDR_WIDTH: start byte address.
- i_u2a_len in 16: total AXI beats minus 1.
- o_user_data out P_USER_DATA_WIDTH: read word.
- o_user_valid out 1: word valid.
- i_user_ready in 1: word accepted.
- o_user_last out 1: final word of the command.
- o_user_err out 1: the current word's beat had RRESP[1]=1.
- o_err_sticky out 1: an error occurred during the current/last command.
- o_busy out 1: a command is in progress.
- o_axi_arvalid out 1, i_axi_arready in 1, o_axi_araddr out P_AXI_ADDR_WIDTH, o_axi_arlen out 8.
- o_axi_arsize out 3, o_axi_arburst out 2, o_axi_arid out 4, o_axi_arlock out 1, o_axi_arcache out 4, o_axi_arprot out 3, o_axi_arqos out 4.
- i_axi_rid in 4, i_axi_rdata in P_AXI_DATA_WIDTH, i_axi_rresp in 2, i_axi_rvalid in 1, i_axi_rlast in 1, o_axi_rready out 1.

Behaviour:
- Reset (i_rst_n=0, async) values:
  - All registered outputs 0.
  - FSM in IDLE; outstanding count 0; holding register empty.
  - o_axi_rready=1 (holding register empty).
  - A reset mid-command abandons in-flight bursts; the system must reset the slave side together with this block.
- Constant outputs:
  - arsize = log2(P_AXI_DATA_WIDTH/8), arburst=2'b01, arid=P_AXI_ID.
  - arlock=0, arcache=4'h3, arprot=0, arqos=0.
- Command handshake:
  - o_u2a_ready=1 only in IDLE; the command is accepted when valid&ready.
  - Address low log2(bytes/beat) bits are forced to 0.
  - Accepting a command loads remaining=len+1 and cur_addr, clears o_err_sticky, and sets o_busy.
- FSM states and transitions:
  - IDLE -> ISSUE on accept.
  - ISSUE: each AR handshake decrements remaining by burst beats; ISSUE -> DRAIN when remaining reaches 0 on a handshake.
  - DRAIN -> IDLE on the cycle the last user word is accepted (o_user_valid & o_user_last & i_user_ready). o_busy clears in that same transition.
- Burst size:
  - beats = min(remaining, P_MAX_BURST, (4096 - cur_addr[11:0]) / bytes_per_beat).
  - arlen = beats-1; araddr = cur_addr.
  - After the handshake, cur_addr += beats*bytes_per_beat. Beats is computed and registered before arvalid rises.
- AR channel:
  - arvalid asserts in ISSUE only when outstanding < P_MAX_OUTSTANDING.
  - Once asserted, arvalid/araddr/arlen are held stable until arready.
  - There is no combinational path from arready to arvalid.
- Outstanding count:
  - +1 on AR handshake; -1 on R handshake with rlast.
  - Both in the same cycle -> unchanged. It never exceeds P_MAX_OUTSTANDING.
- R channel / downsizer:
  - A one-beat holding register captures rdata and rresp on an R handshake.
  - o_axi_rready = !hold_valid | (hold_valid & slice==R-1 & i_user_ready), so a back-to-back beat is accepted with no bubble.
  - Slices are emitted LSB first: o_user_data = hold[slice*W +: W]. The slice counter advances on o_user_valid&i_user_ready and wraps R-1 -> 0.
  - o_user_valid = hold_valid. o_user_data holds while o_user_valid & !i_user_ready.
  - Latency: R beat accepted at cycle t -> first user word valid at t+1.
- Last / error:
  - A beats-received counter is compared against len. o_user_last=1 only on slice R-1 of beat len.
  - i_axi_rlast is used only for outstanding accounting.
  - o_user_err = held rresp[1] for all R slices of that beat.
  - o_err_sticky sets on any accepted beat with rresp[1]=1 and holds until the next command accept.
- i_axi_rid is ignored (single ID, in-order). With R=1, the holding register acts as a pass-through stage with the same timing.

Test Plan:
- Single beat: addr 0x100, len 0, defaults -> one AR (araddr 0x100, arlen 0, arsize 4), then 8 user words from rdata[15:0] up to [127:112]; o_user_last on the 8th; IDLE one cycle after the 8th accept.
- Max-burst split: addr 0x000, len 39 -> AR arlen 15 @0x000, arlen 15 @0x100, arlen 7 @0x200; 320 user words; o_user_last only on word 320.
- 4 KB crossing: addr 0xF80, len 15 -> AR arlen 7 @0xF80, then arlen 7 @0x1000; neither burst crosses 0x1000.
- Outstanding limit: arready=1, rvalid=0, len 127 -> exactly 4 AR handshakes, then arvalid=0. Returning one full burst with rlast -> exactly one more AR issued.
- Backpressure: i_user_ready toggling 1/0 every cycle, rvalid=1 continuously -> rready low while the holding register is occupied; the word sequence is exact and complete, with no duplicated or dropped words.
- Error and reset: rresp=2'b10 on beat 2 of len 3 -> o_user_err=1 on words 17..24 and o_err_sticky=1 until the next command accept. Pulling i_rst_n low mid-burst -> the same cycle gives arvalid=0, o_user_valid=0, o_busy=0, o_u2a_ready=0, rready=1.
